// File: rtl/htif_pkg.sv
// Shared constants and types for the HTIF host mailbox responder.
package htif_pkg;
  localparam logic [7:0] DEV_CONSOLE = 8'h01;
  localparam logic [7:0] CMD_GETC    = 8'h00;
  localparam logic [7:0] CMD_PUTC    = 8'h01;
  localparam logic [7:0] HTIF_ERR    = 8'hFF;

  typedef enum logic [2:0] {IDLE, PUT, GET, RESP, DONE} htif_state_t;

  typedef struct packed {
    logic [7:0] dev;
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] tag;
  } htif_cmd_t;
endpackage

// File: rtl/htif_if.sv
// Mailbox and console signals between the core/bench side and the host responder.
interface htif_if;
  logic        tohost_we;
  logic [31:0] tohost;
  logic        fromhost_we;
  logic [31:0] fromhost;
  logic        cout_valid;
  logic [7:0]  cout_data;
  logic        cout_ready;
  logic        cin_valid;
  logic [7:0]  cin_data;
  logic        cin_ready;
  logic        done;
  logic        pass;
  logic [30:0] exit_code;
  logic        overrun;

  modport slave (
    input  tohost_we, tohost, cout_ready, cin_valid, cin_data,
    output fromhost_we, fromhost, cout_valid, cout_data, cin_ready,
           done, pass, exit_code, overrun
  );

  modport master (
    output tohost_we, tohost, cout_ready, cin_valid, cin_data,
    input  fromhost_we, fromhost, cout_valid, cout_data, cin_ready,
           done, pass, exit_code, overrun
  );
endinterface

// File: rtl/htif_fifo.sv
// Synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module htif_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  logic [W-1:0] mem [DEPTH];
  ptr_t         wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ptr_t'(1);
      if (pop)  rptr <= rptr + ptr_t'(1);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/htif_host.sv
// Host-side tohost/fromhost responder: exit latch, console putchar/getchar, one ack per command.
module htif_host
  import htif_pkg::*;
#(
  parameter int TX_DEPTH   = 4,
  parameter int RESP_DELAY = 0
) (
  input  logic CLK,
  input  logic RSTn,
  htif_if.slave bus
);
  htif_state_t state;
  htif_cmd_t   cmd_in, cmd_q;
  logic [31:0] resp_q, resp_val;
  logic [7:0]  cnt;
  logic        resp_load, push, pop, full, empty;

  assign cmd_in         = htif_cmd_t'(bus.tohost);
  assign pop            = !empty && bus.cout_ready;
  // A same-cycle pop frees the slot, so a full FIFO can still accept the push.
  assign push           = (state == PUT) && (!full || pop);
  assign bus.cout_valid = !empty;
  assign bus.cin_ready  = (state == GET);

  htif_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx (
    .CLK(CLK), .RSTn(RSTn),
    .push(push), .din(cmd_q.data), .pop(pop),
    .dout(bus.cout_data), .full(full), .empty(empty)
  );

  always_comb begin
    resp_load = 1'b0;
    resp_val  = '0;
    unique case (state)
      IDLE: if (bus.tohost_we && bus.tohost != '0 && !bus.tohost[0] &&
                !(cmd_in.dev == DEV_CONSOLE &&
                  (cmd_in.cmd == CMD_PUTC || cmd_in.cmd == CMD_GETC))) begin
        resp_load = 1'b1;
        resp_val  = {cmd_in.dev, HTIF_ERR, HTIF_ERR, cmd_in.tag};
      end
      PUT: if (push) begin
        resp_load = 1'b1;
        resp_val  = {cmd_q.dev, cmd_q.cmd, cmd_q.data, cmd_q.tag};
      end
      GET: if (bus.cin_valid) begin
        resp_load = 1'b1;
        resp_val  = {cmd_q.dev, cmd_q.cmd, bus.cin_data, cmd_q.tag};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state           <= IDLE;
      cmd_q           <= '0;
      resp_q          <= '0;
      cnt             <= '0;
      bus.fromhost_we <= 1'b0;
      bus.fromhost    <= '0;
      bus.done        <= 1'b0;
      bus.pass        <= 1'b0;
      bus.exit_code   <= '0;
      bus.overrun     <= 1'b0;
    end else begin
      bus.fromhost_we <= 1'b0;
      if (bus.tohost_we && (state == PUT || state == GET || state == RESP))
        bus.overrun <= 1'b1;
      if (resp_load) begin
        state  <= RESP;
        resp_q <= resp_val;
        cnt    <= 8'(RESP_DELAY);
        // The strobe is registered, so a zero delay fires on the entry edge.
        if (RESP_DELAY == 0) begin
          bus.fromhost_we <= 1'b1;
          bus.fromhost    <= resp_val;
        end
      end else begin
        unique case (state)
          IDLE: if (bus.tohost_we && bus.tohost != '0) begin
            cmd_q <= cmd_in;
            if (bus.tohost[0]) begin
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.pass      <= (bus.tohost == 32'h1);
              bus.exit_code <= bus.tohost[31:1];
            end else if (cmd_in.cmd == CMD_PUTC) begin
              state <= PUT;
            end else begin
              state <= GET;
            end
          end
          RESP: if (cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              bus.fromhost_we <= 1'b1;
              bus.fromhost    <= resp_q;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_htif_host.sv
// Directed bench for htif_host: dut a uses RESP_DELAY=0, dut b uses RESP_DELAY=3.
module tb_htif_host;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  htif_if a ();
  htif_if b ();

  htif_host #(.TX_DEPTH(4), .RESP_DELAY(0)) dut_a (.CLK(CLK), .RSTn(RSTn), .bus(a));
  htif_host #(.TX_DEPTH(4), .RESP_DELAY(3)) dut_b (.CLK(CLK), .RSTn(RSTn), .bus(b));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    a.tohost_we = 0; a.tohost = '0; a.cout_ready = 0; a.cin_valid = 0; a.cin_data = '0;
    b.tohost_we = 0; b.tohost = '0; b.cout_ready = 0; b.cin_valid = 0; b.cin_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RSTn = 1'b0;
    tick(); tick();
    RSTn = 1'b1;
    tick();
  endtask

  task automatic wr_a(input logic [31:0] v);
    a.tohost = v; a.tohost_we = 1'b1;
    tick();
    a.tohost_we = 1'b0;
  endtask

  task automatic wr_b(input logic [31:0] v);
    b.tohost = v; b.tohost_we = 1'b1;
    tick();
    b.tohost_we = 1'b0;
  endtask

  // Waits for the next fromhost strobe on dut a, checks its value, then steps past it.
  task automatic wait_resp_a(input string nm, input logic [31:0] exp);
    bit seen;
    seen = 0;
    for (int n = 0; n < 12 && !seen; n++) begin
      if (a.fromhost_we) begin
        seen = 1;
        checks++;
        if (a.fromhost !== exp) begin
          failures++;
          $display("FAIL %s: fromhost=%h expected %h", nm, a.fromhost, exp);
        end
      end
      tick();
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s: no fromhost_we within bound", nm);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({a.done, a.pass, a.overrun, a.fromhost_we, a.cout_valid, a.cin_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags_a: got %b expected 000000",
               {a.done, a.pass, a.overrun, a.fromhost_we, a.cout_valid, a.cin_ready});
    end
    checks++;
    if (a.fromhost !== 32'h0 || a.exit_code !== 31'h0) begin
      failures++;
      $display("FAIL reset_values_a: fromhost=%h exit_code=%h expected 0", a.fromhost, a.exit_code);
    end
    checks++;
    if ({b.done, b.overrun, b.fromhost_we, b.cout_valid, b.cin_ready} !== 5'b0 || b.fromhost !== 32'h0) begin
      failures++;
      $display("FAIL reset_b: flags=%b fromhost=%h expected 0",
               {b.done, b.overrun, b.fromhost_we, b.cout_valid, b.cin_ready}, b.fromhost);
    end
  endtask

  task automatic test_exit_pass();
    do_reset();
    wr_a(32'h1);
    checks++;
    if (a.done !== 1'b1 || a.pass !== 1'b1 || a.exit_code !== 31'd0) begin
      failures++;
      $display("FAIL exit_pass: done=%b pass=%b code=%0d expected 1 1 0", a.done, a.pass, a.exit_code);
    end
    wr_a(32'h5);
    tick();
    checks++;
    if (a.done !== 1'b1 || a.pass !== 1'b1 || a.exit_code !== 31'd0 || a.overrun !== 1'b0) begin
      failures++;
      $display("FAIL exit_sticky: done=%b pass=%b code=%0d overrun=%b expected 1 1 0 0",
               a.done, a.pass, a.exit_code, a.overrun);
    end
  endtask

  task automatic test_exit_fail();
    do_reset();
    wr_a(32'h0000_0007);
    checks++;
    if (a.done !== 1'b1 || a.pass !== 1'b0 || a.exit_code !== 31'd3) begin
      failures++;
      $display("FAIL exit_fail: done=%b pass=%b code=%0d expected 1 0 3", a.done, a.pass, a.exit_code);
    end
  endtask

  task automatic test_zero_ignored();
    do_reset();
    wr_a(32'h0);
    tick(); tick();
    checks++;
    if (a.done !== 1'b0 || a.fromhost_we !== 1'b0 || a.overrun !== 1'b0) begin
      failures++;
      $display("FAIL zero_ignored: done=%b fromhost_we=%b overrun=%b expected 0 0 0",
               a.done, a.fromhost_we, a.overrun);
    end
  endtask

  task automatic test_putc();
    do_reset();
    a.cout_ready = 1'b1;
    wr_a(32'h0101_4102);
    checks++;
    if (a.fromhost_we !== 1'b0 || a.cout_valid !== 1'b0) begin
      failures++;
      $display("FAIL putc_c1: fromhost_we=%b cout_valid=%b expected 0 0", a.fromhost_we, a.cout_valid);
    end
    tick();
    checks++;
    if (a.cout_valid !== 1'b1 || a.cout_data !== 8'h41) begin
      failures++;
      $display("FAIL putc_cout: valid=%b data=%h expected 1 41", a.cout_valid, a.cout_data);
    end
    checks++;
    if (a.fromhost_we !== 1'b1 || a.fromhost !== 32'h0101_4102) begin
      failures++;
      $display("FAIL putc_resp: we=%b fromhost=%h expected 1 01014102", a.fromhost_we, a.fromhost);
    end
    tick();
    checks++;
    if (a.fromhost_we !== 1'b0 || a.cout_valid !== 1'b0 || a.fromhost !== 32'h0101_4102) begin
      failures++;
      $display("FAIL putc_after: we=%b valid=%b fromhost=%h expected 0 0 01014102",
               a.fromhost_we, a.cout_valid, a.fromhost);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      v = {8'h01, 8'h01, 8'(8'h30 + i), 8'(2 * (i + 1))};
      wr_a(v);
      wait_resp_a("bp_fill", v);
    end
    v = 32'h0101_340A;
    wr_a(v);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (a.fromhost_we !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall: cycle %0d fromhost_we=%b expected 0", c, a.fromhost_we);
      end
      if (c < 5) tick();
    end
    checks++;
    if (a.cout_valid !== 1'b1 || a.cout_data !== 8'h30) begin
      failures++;
      $display("FAIL bp_head: valid=%b data=%h expected 1 30", a.cout_valid, a.cout_data);
    end
    a.cout_ready = 1'b1;
    tick();
    a.cout_ready = 1'b0;
    checks++;
    if (a.fromhost_we !== 1'b1 || a.fromhost !== v) begin
      failures++;
      $display("FAIL bp_fifth: we=%b fromhost=%h expected 1 %h", a.fromhost_we, a.fromhost, v);
    end
    a.cout_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a.cout_valid !== 1'b1 || a.cout_data !== 8'(8'h31 + i)) begin
        failures++;
        $display("FAIL bp_order: slot %0d valid=%b data=%h expected 1 %h",
                 i, a.cout_valid, a.cout_data, 8'(8'h31 + i));
      end
      tick();
    end
    checks++;
    if (a.cout_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_empty: cout_valid=%b expected 0", a.cout_valid);
    end
    a.cout_ready = 1'b0;
  endtask

  task automatic test_getc();
    do_reset();
    wr_a(32'h0100_0004);
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (a.cin_ready !== 1'b1 || a.fromhost_we !== 1'b0) begin
        failures++;
        $display("FAIL getc_wait: cycle %0d cin_ready=%b we=%b expected 1 0", c, a.cin_ready, a.fromhost_we);
      end
      if (c == 3) begin
        a.cin_valid = 1'b1; a.cin_data = 8'h5A;
      end
      tick();
    end
    a.cin_valid = 1'b0; a.cin_data = 8'h00;
    checks++;
    if (a.fromhost_we !== 1'b1 || a.fromhost !== 32'h0100_5A04 || a.cin_ready !== 1'b0) begin
      failures++;
      $display("FAIL getc_resp: we=%b fromhost=%h cin_ready=%b expected 1 01005a04 0",
               a.fromhost_we, a.fromhost, a.cin_ready);
    end
    tick();
    checks++;
    if (a.fromhost_we !== 1'b0) begin
      failures++;
      $display("FAIL getc_pulse: we=%b expected 0", a.fromhost_we);
    end
  endtask

  task automatic test_err_overrun();
    do_reset();
    b.cout_ready = 1'b1;
    wr_b(32'h0203_0008);
    wr_b(32'h0101_4202);
    for (int c = 2; c <= 3; c++) begin
      checks++;
      if (b.fromhost_we !== 1'b0 || b.overrun !== 1'b1) begin
        failures++;
        $display("FAIL err_wait: cycle %0d we=%b overrun=%b expected 0 1", c, b.fromhost_we, b.overrun);
      end
      tick();
    end
    checks++;
    if (b.fromhost_we !== 1'b1 || b.fromhost !== 32'h02FF_FF08) begin
      failures++;
      $display("FAIL err_resp: we=%b fromhost=%h expected 1 02ffff08", b.fromhost_we, b.fromhost);
    end
    for (int c = 5; c < 16; c++) begin
      tick();
      checks++;
      if (b.fromhost_we !== 1'b0 || b.cout_valid !== 1'b0) begin
        failures++;
        $display("FAIL err_dropped: cycle %0d we=%b cout_valid=%b expected 0 0", c, b.fromhost_we, b.cout_valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr_a(32'h0101_6102);
    wr_a(32'h0101_6204);
    tick();
    checks++;
    if (a.overrun !== 1'b1 || a.cout_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: overrun=%b cout_valid=%b expected 1 1", a.overrun, a.cout_valid);
    end
    RSTn = 1'b0;
    #1;
    checks++;
    if (a.overrun !== 1'b0 || a.cout_valid !== 1'b0 || a.fromhost !== 32'h0) begin
      failures++;
      $display("FAIL midrst: overrun=%b cout_valid=%b fromhost=%h expected 0 0 0",
               a.overrun, a.cout_valid, a.fromhost);
    end
    tick();
    RSTn = 1'b1;
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_exit_pass();
    test_exit_fail();
    test_zero_ignored();
    test_putc();
    test_backpressure();
    test_getc();
    test_err_overrun();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
